// File: rtl/apb_wait_regs_completer.sv
// APB4 scratch-register completer with programmable PREADY wait states
// and PSLVERR on unmapped, read-only or privilege-violating accesses.
module apb_wait_regs_completer #(
  parameter int          ADDRWIDTH  = 12,
  parameter logic [3:0]  WAIT_RESET = 4'd0,
  parameter logic [31:0] ID_VALUE   = 32'h0A5B_0001
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic [2:0]           PPROT,
  input  logic [3:0]           PSTRB,
  input  logic [31:0]          PWDATA,
  output logic [31:0]          PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACCESS = 1'b1;

  logic        state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:0] data_q [8];
  logic [31:0] data_d [8];
  logic [3:0]  waitcfg_q, waitcfg_d;
  logic        ctrl_q, ctrl_d;
  logic [15:0] acccnt_q, acccnt_d;
  logic [7:0]  errcnt_q, errcnt_d;

  logic [3:0]  idx;
  logic        hi_zero;
  logic        is_data, is_wait, is_ctrl;
  logic        is_acc, is_err, is_id;
  logic        mapped, err;
  logic        ready;
  logic        commit;
  logic [31:0] rdata;
  logic        unused_bits;

  assign unused_bits = ^{PPROT[2:1], PADDR[1:0]};

  assign idx     = PADDR[5:2];
  assign hi_zero = (PADDR[ADDRWIDTH-1:6] == '0);
  assign is_data = hi_zero && !idx[3];
  assign is_wait = hi_zero && (idx == 4'd8);
  assign is_ctrl = hi_zero && (idx == 4'd9);
  assign is_acc  = hi_zero && (idx == 4'd10);
  assign is_err  = hi_zero && (idx == 4'd11);
  assign is_id   = hi_zero && (idx == 4'd12);
  assign mapped  = is_data | is_wait | is_ctrl
                 | is_acc | is_err | is_id;

  assign err = !mapped
             | (PWRITE & (is_acc | is_err | is_id))
             | (ctrl_q & !PPROT[0]);

  assign ready  = PRESETn && (state_q == ST_ACCESS)
               && (wcnt_q == 4'd0);
  assign commit = ready && PSEL && PENABLE;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_data: rdata = data_q[idx[2:0]];
      is_wait: rdata = {28'd0, waitcfg_q};
      is_ctrl: rdata = {31'd0, ctrl_q};
      is_acc:  rdata = {16'd0, acccnt_q};
      is_err:  rdata = {24'd0, errcnt_q};
      is_id:   rdata = ID_VALUE;
      default: rdata = '0;
    endcase
  end

  assign PREADY  = ready;
  assign PSLVERR = ready && err;
  assign PRDATA  = (ready && !PWRITE && !err) ? rdata : '0;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    data_d    = data_q;
    waitcfg_d = waitcfg_q;
    ctrl_d    = ctrl_q;
    acccnt_d  = acccnt_q;
    errcnt_d  = errcnt_q;
    if (state_q == ST_IDLE) begin
      if (PSEL && !PENABLE) begin
        state_d = ST_ACCESS;
        wcnt_d  = waitcfg_q;
      end
    end else if (!PSEL) begin
      // initiator abandoned the transfer: drop it silently
      state_d = ST_IDLE;
    end else if (PENABLE) begin
      if (wcnt_q != 4'd0) begin
        wcnt_d = wcnt_q - 4'd1;
      end else begin
        state_d  = ST_IDLE;
        acccnt_d = acccnt_q + 16'd1;
        if (err && errcnt_q != 8'hFF)
          errcnt_d = errcnt_q + 8'd1;
        if (PWRITE && !err) begin
          if (is_data) begin
            for (int b = 0; b < 4; b++)
              if (PSTRB[b])
                data_d[idx[2:0]][8*b +: 8] = PWDATA[8*b +: 8];
          end
          if (is_wait && PSTRB[0])
            waitcfg_d = PWDATA[3:0];
          if (is_ctrl && PSTRB[0])
            ctrl_d = PWDATA[0];
        end
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= 4'd0;
      for (int i = 0; i < 8; i++)
        data_q[i] <= '0;
      waitcfg_q <= WAIT_RESET;
      ctrl_q    <= 1'b0;
      acccnt_q  <= '0;
      errcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      for (int i = 0; i < 8; i++)
        data_q[i] <= data_d[i];
      waitcfg_q <= waitcfg_d;
      ctrl_q    <= ctrl_d;
      acccnt_q  <= acccnt_d;
      errcnt_q  <= errcnt_d;
    end
  end

  // commit is only a name for the completing cycle; keep it observable
  logic unused_commit;
  assign unused_commit = commit;

endmodule

// File: doc/apb_wait_regs_completer.md
Name: apb_wait_regs_completer

Overview:
APB4 completer that sits on the APB side of the async AHB-to-APB bridge and answers that bridge's APB initiator. It holds eight general-purpose registers plus control and status registers. It inserts a programmable number of wait states through PREADY and signals PSLVERR on unmapped, read-only or privilege-violating accesses. It is the bench target for bridge wait-state and error-path testing, and a reusable scratch peripheral.

Parameters:
ADDRWIDTH, 12, APB address width. Only PADDR[5:2] is decoded; PADDR[ADDRWIDTH-1:6] must be zero, otherwise the access is unmapped.
WAIT_RESET, 4'd0, reset value of WAITCFG.
ID_VALUE, 32'h0A5B_0001, constant returned by the ID register.

Ports:
PCLK  input  1  peripheral clock, sole clock
PRESETn  input  1  reset, synchronous, active-low
PSEL  input  1  APB select
PENABLE  input  1  APB enable (access phase)
PWRITE  input  1  1 = write
PADDR  input  ADDRWIDTH  byte address; bits [1:0] ignored
PPROT  input  3  protection; only bit 0 (privileged) is used
PSTRB  input  4  write byte strobes
PWDATA  input  32  write data
PRDATA  output  32  read data
PREADY  output  1  transfer complete
PSLVERR  output  1  error response, valid only with PREADY

Behaviour:
Register map (word offsets):
- 0x00-0x1C DATA0-7: RW, reset 0. A write updates only the bytes whose PSTRB bit is set.
- 0x20 WAITCFG: RW [3:0], reset WAIT_RESET. Upper bits read 0. PSTRB[0] gates the write.
- 0x24 CTRL: RW [0] PRIV_ONLY, reset 0.
- 0x28 ACCCNT: RO [15:0], counts completed transfers (errors included), wraps 0xFFFF->0.
- 0x2C ERRCNT: RO [7:0], counts PSLVERR responses, saturates at 0xFF.
- 0x30 ID: RO, returns ID_VALUE.
- Every other offset is unmapped.

Error conditions (PSLVERR=1):
- Unmapped address.
- Write to ACCCNT, ERRCNT or ID.
- CTRL.PRIV_ONLY=1 and PPROT[0]=0, on any register including CTRL.
- An errored write changes no register. An errored read returns PRDATA=0.

FSM states: IDLE, ACCESS.
- IDLE: on PSEL & ~PENABLE (setup phase), load wcnt <= WAITCFG and go to ACCESS.
- ACCESS: PREADY = (wcnt==0).
  - If PSEL & PENABLE & wcnt!=0: decrement wcnt.
  - If PSEL & PENABLE & wcnt==0: commit the transfer and go to IDLE.
  - If PSEL drops (initiator violation): go to IDLE with no commit and no counter update.
- A back-to-back setup phase in the cycle after completion is accepted from IDLE normally.
- Transfer length: WAITCFG=N gives N+2 PCLK cycles (setup + N waits + final access cycle).
- A write to WAITCFG takes effect from the next setup phase, never the current transfer.

Outputs:
- PREADY is combinational from state and wcnt. It is 0 in IDLE.
- PRDATA is the selected register when PREADY & ~PWRITE & no error, else 0.
- PSLVERR is the error decode gated by PREADY, else 0.
- Address, write flag and PPROT are sampled from the live bus in the completing cycle (APB holds them stable).

Commit at the PCLK edge ending the completing cycle:
- Write register (if no error).
- ACCCNT+1.
- ERRCNT+1 if error and not 0xFF.

Counter-read corner cases:
- A read of ACCCNT or ERRCNT returns the pre-increment value.
- A read of ACCCNT at 0xFFFF returns 0xFFFF, and the counter then wraps to 0.

Reset:
- PRESETn low at a PCLK edge returns FSM to IDLE and wcnt to 0.
- All registers go to reset values, counters to 0.
- This holds mid-transfer; the in-flight transfer is dropped uncommitted.
- Outputs are 0 during reset.

Test Plan:
- Reset, then read ID with WAITCFG=0: PREADY high in the 2nd cycle, PRDATA=0x0A5B0001, PSLVERR=0. Then ACCCNT reads 1.
- Write 0xDEADBEEF to DATA3 with PSTRB=4'b0101, then read DATA3: returns 0x00AD00EF.
- Write WAITCFG=3, then read DATA0: PREADY low for 3 access cycles, high on the 4th, 5 cycles total; the WAITCFG write itself took 2 cycles.
- Write to 0x3C and to ERRCNT: both PSLVERR=1 with no register change. ERRCNT then reads 2; ACCCNT reads 3 (2 errored writes plus the ERRCNT read).
- Set CTRL=1 with PPROT=3'b001, then do an unprivileged read of DATA0: PSLVERR=1, PRDATA=0. A privileged write CTRL=0 succeeds.
- Assert PRESETn low in the 2nd wait cycle of a DATA5 write with WAITCFG=4: DATA5 stays 0, PREADY=0, and the next transfer after reset completes in 2 cycles.
